bcd_seg_display: RTL and testbench
==================================

// Module: bcd_seg_display
// PURPOSE
//  Downstream display stage for the CPU core. Accepts a binary result (e.g. a register write value) over a valid/ready handshake.
//  Converts it to BCD with a sequential double-dabble engine, one bit per clock. Drives four active-low 7-segment digits.
//  Replaces the per-digit /,% combinational dividers in the core with a small registered converter.
// PARAMETERS
//  WIDTH          16  binary input width; legal range 4..16
//  DIGITS         4   displayed digits; internal scratch is always 5 BCD digits
//  BLANK_LEADING  0   1: blank leading zero digits (digit 0 is never blanked)
// PORTS
//  clk        in   1          system clock (50 MHz), rising-edge
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          upstream has a value to display
//  in_value   in   WIDTH      unsigned binary value
//  in_blank   in   1          sampled with in_value; 1 = show nothing
//  in_ready   out  1          converter idle; transfer occurs when in_valid & in_ready
//  busy       out  1          conversion in progress (equals !in_ready)
//  bcd        out  4*DIGITS   committed BCD; digit i is at [4i+3:4i]
//  overflow   out  1          committed value > 10^DIGITS-1
//  hex_n      out  7*DIGITS   segments; digit i is at [7i+6:7i], bit0=a .. bit6=g, 0 = lit
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is asynchronous and active-high.
//  Reset values: hex_n all 1 (dark), bcd=0, overflow=0, in_ready=1, busy=0, FSM=IDLE.
//  FSM states: IDLE -> SHIFT -> COMMIT -> IDLE.
//   IDLE: in_ready=1. On edge with in_valid=1, do all of the following and go to SHIFT:
//    - load in_value into the shift register;
//    - clear the 20-bit BCD scratch;
//    - set cnt=WIDTH;
//    - latch in_blank.
//   SHIFT: each edge, for every scratch nibble >=5 add 3, then shift {scratch,bin} left by 1 and decrement cnt.
//    When cnt reaches 0 after that edge, go to COMMIT.
//   COMMIT: one edge updates bcd, overflow and hex_n from the scratch, then returns to IDLE.
//  Latency: accept at edge N; outputs and in_ready=1 are valid after edge N+WIDTH+1 (17 for WIDTH=16).
//   Throughput is one value per WIDTH+2 clocks.
//  Outputs hold their last committed values during SHIFT/COMMIT. There is no flicker of partial results.
//  in_valid while busy is ignored; there is no queue. Upstream holds or drops its data.
//  Overflow: overflow=1 if any scratch digit >= DIGITS is nonzero. bcd/hex_n still show the low DIGITS digits (value mod 10^DIGITS).
//  Segment code for digit d (hex_n[7i+6:7i], g..a):
//   0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//   5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//  Latched in_blank=1: every hex_n bit is 1. bcd and overflow still update.
//  BLANK_LEADING=1: a digit i>0 is dark when it and all higher displayed digits are 0. Overflow does not inhibit blanking.
//  rst mid-conversion: abort immediately to reset values. The partial result is discarded.
//  Scratch nibbles never exceed 9 after an add-3/shift step. This is a sim-only assertion.
//  in_value bits above WIDTH do not exist. For WIDTH<16, the scratch MSBs stay 0.
// TESTING
//  1 rst pulse mid-idle -> hex_n=28'hFFFFFFF, bcd=0, in_ready=1, overflow=0.
//  2 in_value=1234, valid 1 cycle -> in_ready=0 for 17 clocks; then bcd=16'h1234, digit3..0=1111001/0100100/0110000/0011001.
//  3 9999 -> bcd=16'h9999, overflow=0; 10000 -> bcd=0, overflow=1; 65535 -> bcd=16'h5535, overflow=1.
//  4 value 0: BLANK_LEADING=0 -> all digits 1000000; BLANK_LEADING=1 -> digits 3..1 all 1, digit0=1000000; value 40 -> digits 3..2 dark.
//  5 in_blank=1, value 42 -> hex_n all 1, bcd=16'h0042; next value 7 with in_blank=0 -> digit0=1111000.
//  6 in_value=500 accepted; hold in_valid=1 with in_value=77 during busy -> 77 not taken until in_ready returns.
//    rst at clock 5 of a conversion -> reset values restored, next value 8 converts normally (bcd=16'h0008).

Source files
------------

// File: rtl/bcd_seg_display.sv
// Registered binary-to-BCD display stage: a double-dabble engine converts one bit per clock,
// then a single commit edge updates the BCD, overflow and active-low 7-segment outputs together.
module bcd_seg_display #(
  parameter int WIDTH         = 16,
  parameter int DIGITS        = 4,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  in_blank,
  output logic                  in_ready,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex_n
);

  localparam int SCR_DIGITS = 5;
  localparam int SCR_W      = 4 * SCR_DIGITS;
  localparam int CNT_W      = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     bin_r;
  logic [SCR_W-1:0]     scratch_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 blank_r;
  logic                 carry_r;
  logic [SCR_W-1:0]     adj_s;
  logic [7*DIGITS-1:0]  hex_next_s;
  logic                 ov_next_s;

  function automatic logic [SCR_W-1:0] dabble_adjust(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int i = 0; i < SCR_DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Leading-zero suppression walks from the top digit down; digit 0 always shows.
  function automatic logic [7*DIGITS-1:0] render(input logic [SCR_W-1:0] s, input logic blank);
    logic [7*DIGITS-1:0] h;
    logic                higher_zero;
    h           = {(7*DIGITS){1'b1}};
    higher_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero & (s[4*i +: 4] == 4'd0);
      if (blank || (BLANK_LEADING && (i != 0) && higher_zero)) begin
        h[7*i +: 7] = 7'b1111111;
      end else begin
        h[7*i +: 7] = seg7(s[4*i +: 4]);
      end
    end
    return h;
  endfunction

  function automatic logic over_range(input logic [SCR_W-1:0] s, input logic carry);
    logic o;
    o = carry;
    for (int i = 0; i < SCR_DIGITS; i++) begin
      if ((i >= DIGITS) && (s[4*i +: 4] != 4'd0)) begin
        o = 1'b1;
      end else begin
        o = o;
      end
    end
    return o;
  endfunction

  // Next-step and commit-time values derived from the current scratch.
  always_comb begin
    adj_s      = dabble_adjust(scratch_r);
    hex_next_s = render(scratch_r, blank_r);
    ov_next_s  = over_range(scratch_r, carry_r);
  end

  // Conversion FSM with registered handshake and display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      bin_r     <= {WIDTH{1'b0}};
      scratch_r <= {SCR_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      blank_r   <= 1'b0;
      carry_r   <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      bcd       <= {(4*DIGITS){1'b0}};
      overflow  <= 1'b0;
      hex_n     <= {(7*DIGITS){1'b1}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            bin_r     <= in_value;
            scratch_r <= {SCR_W{1'b0}};
            cnt_r     <= CNT_W'(WIDTH);
            blank_r   <= in_blank;
            carry_r   <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state_r   <= SHIFT;
          end
        end
        SHIFT: begin
          // A bit pushed out of the top digit can only mean lost magnitude; keep it as overflow.
          scratch_r <= {adj_s[SCR_W-2:0], bin_r[WIDTH-1]};
          carry_r   <= carry_r | adj_s[SCR_W-1];
          bin_r     <= {bin_r[WIDTH-2:0], 1'b0};
          cnt_r     <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r <= COMMIT;
          end
        end
        COMMIT: begin
          bcd      <= scratch_r[4*DIGITS-1:0];
          overflow <= ov_next_s;
          hex_n    <= hex_next_s;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  bcd_seg_display_chk #(
    .SCR_W (SCR_W)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .scratch  (scratch_r),
    .carry    (carry_r),
    .in_ready (in_ready),
    .busy     (busy)
  );

endmodule

// Simulation checks on the converter's internal invariants.
module bcd_seg_display_chk #(
  parameter int SCR_W = 20
) (
  input logic             clk,
  input logic             rst,
  input logic [SCR_W-1:0] scratch,
  input logic             carry,
  input logic             in_ready,
  input logic             busy
);

  for (genvar g = 0; g < SCR_W / 4; g++) begin : g_nib
    a_nib_bcd: assert property (@(posedge clk) disable iff (rst) scratch[4*g +: 4] <= 4'd9);
  end

  a_no_carry:   assert property (@(posedge clk) disable iff (rst) carry == 1'b0);
  a_busy_ready: assert property (@(posedge clk) disable iff (rst) busy == !in_ready);

endmodule

// File: tb/tb_bcd_seg_display.sv
// Self-checking bench for bcd_seg_display: two instances (leading-zero blanking off/on)
// compared against a decimal-arithmetic reference model.
module tb_bcd_seg_display;

  localparam int W = 16;
  localparam int D = 4;
  localparam int LAT = W + 1;
  localparam logic [6:0] SEG_LUT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_value;
  logic          in_blank;
  logic          ready0, busy0, ov0, ready1, busy1, ov1;
  logic [15:0]   bcd0, bcd1;
  logic [27:0]   hex0, hex1;

  int vec    = 0;
  int miscmp = 0;

  always #5 clk = ~clk;

  bcd_seg_display #(.WIDTH(W), .DIGITS(D), .BLANK_LEADING(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value), .in_blank(in_blank),
    .in_ready(ready0), .busy(busy0), .bcd(bcd0), .overflow(ov0), .hex_n(hex0)
  );

  bcd_seg_display #(.WIDTH(W), .DIGITS(D), .BLANK_LEADING(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value), .in_blank(in_blank),
    .in_ready(ready1), .busy(busy1), .bcd(bcd1), .overflow(ov1), .hex_n(hex1)
  );

  function automatic logic [15:0] exp_bcd(input int v);
    logic [15:0] r;
    int p;
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic exp_ov(input int v);
    return (v > 9999);
  endfunction

  function automatic logic [27:0] exp_hex(input int v, input bit blank, input bit bl);
    logic [27:0] h;
    int low, p;
    low = v % 10000;
    p = 1;
    for (int i = 0; i < D; i++) begin
      if (blank || (bl && i > 0 && (low / p) == 0)) h[7*i +: 7] = 7'h7F;
      else h[7*i +: 7] = SEG_LUT[(low / p) % 10];
      p = p * 10;
    end
    return h;
  endfunction

  // Offers one value, then counts clocks until in_ready returns (-1 if it never does)
  // and reports whether the displayed outputs stayed frozen meanwhile.
  task automatic push(input int v, input bit blank, output int lat, output bit held);
    logic [15:0] b0;
    logic [27:0] h0;
    logic        o0;
    int          guard;
    guard = 0;
    while (!ready0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    b0 = bcd0; h0 = hex0; o0 = ov0; held = 1'b1;
    in_value = v[W-1:0]; in_blank = blank; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (ready0) begin
        lat = c;
        break;
      end
      if (bcd0 !== b0 || hex0 !== h0 || ov0 !== o0) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    int lat;
    bit held;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        push(1234, 1'b0, lat, held);
        #1 rst = 1'b1;
        #1;
      end
      vec++; if (hex0 !== 28'hFFFFFFF || hex1 !== 28'hFFFFFFF) begin miscmp++; $display("FAIL reset_hex k=%0d got %h/%h want fffffff", k, hex0, hex1); end
      vec++; if (bcd0 !== 16'h0000 || ov0 !== 1'b0) begin miscmp++; $display("FAIL reset_bcd k=%0d got %h ov=%b want 0000 ov=0", k, bcd0, ov0); end
      vec++; if (ready0 !== 1'b1 || busy0 !== 1'b0 || ready1 !== 1'b1 || busy1 !== 1'b0) begin miscmp++; $display("FAIL reset_hs k=%0d got rdy=%b busy=%b want rdy=1 busy=0", k, ready0, busy0); end
      if (k == 1) begin
        #1 rst = 1'b0;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_directed();
    int vals [8] = '{1234, 9999, 10000, 65535, 0, 40, 7, 100};
    int lat;
    bit held;
    foreach (vals[n]) begin
      push(vals[n], 1'b0, lat, held);
      vec++; if (lat != LAT) begin miscmp++; $display("FAIL dir_latency v=%0d got %0d want %0d", vals[n], lat, LAT); end
      vec++; if (!held) begin miscmp++; $display("FAIL dir_hold v=%0d got outputs changed while busy want held", vals[n]); end
      vec++; if (bcd0 !== exp_bcd(vals[n])) begin miscmp++; $display("FAIL dir_bcd v=%0d got %h want %h", vals[n], bcd0, exp_bcd(vals[n])); end
      vec++; if (ov0 !== exp_ov(vals[n])) begin miscmp++; $display("FAIL dir_ovf v=%0d got %b want %b", vals[n], ov0, exp_ov(vals[n])); end
      vec++; if (hex0 !== exp_hex(vals[n], 1'b0, 1'b0)) begin miscmp++; $display("FAIL dir_hex v=%0d got %h want %h", vals[n], hex0, exp_hex(vals[n], 1'b0, 1'b0)); end
      vec++; if (hex1 !== exp_hex(vals[n], 1'b0, 1'b1)) begin miscmp++; $display("FAIL dir_hex_bl v=%0d got %h want %h", vals[n], hex1, exp_hex(vals[n], 1'b0, 1'b1)); end
      vec++; if (bcd1 !== exp_bcd(vals[n]) || ov1 !== exp_ov(vals[n])) begin miscmp++; $display("FAIL dir_bcd_bl v=%0d got %h/%b want %h/%b", vals[n], bcd1, ov1, exp_bcd(vals[n]), exp_ov(vals[n])); end
    end
  endtask

  task automatic test_blank();
    int lat;
    bit held;
    push(42, 1'b1, lat, held);
    vec++; if (hex0 !== 28'hFFFFFFF || hex1 !== 28'hFFFFFFF) begin miscmp++; $display("FAIL blank_hex got %h/%h want fffffff", hex0, hex1); end
    vec++; if (bcd0 !== 16'h0042 || ov0 !== 1'b0) begin miscmp++; $display("FAIL blank_bcd got %h ov=%b want 0042 ov=0", bcd0, ov0); end
    push(7, 1'b0, lat, held);
    vec++; if (hex0[6:0] !== 7'b1111000 || hex0 !== exp_hex(7, 1'b0, 1'b0)) begin miscmp++; $display("FAIL unblank_hex got %h want %h", hex0, exp_hex(7, 1'b0, 1'b0)); end
    vec++; if (hex1 !== exp_hex(7, 1'b0, 1'b1)) begin miscmp++; $display("FAIL unblank_hex_bl got %h want %h", hex1, exp_hex(7, 1'b0, 1'b1)); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    bit held;
    in_value = 16'd500; in_blank = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_value = 16'd77;
    vec++; if (ready0 !== 1'b0) begin miscmp++; $display("FAIL busy_accept got rdy=%b want 0", ready0); end
    lat = -1; held = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (ready0) begin lat = c; break; end
      if (bcd0 !== 16'h0007) held = 1'b0;
    end
    vec++; if (lat != LAT) begin miscmp++; $display("FAIL busy_latency got %0d want %0d", lat, LAT); end
    vec++; if (!held) begin miscmp++; $display("FAIL busy_hold got bcd changed while busy want 0007"); end
    vec++; if (bcd0 !== 16'h0500) begin miscmp++; $display("FAIL busy_first got %h want 0500", bcd0); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vec++; if (ready0 !== 1'b0) begin miscmp++; $display("FAIL busy_second_accept got rdy=%b want 0", ready0); end
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (ready0) break;
    end
    vec++; if (bcd0 !== 16'h0077 || hex1 !== exp_hex(77, 1'b0, 1'b1)) begin miscmp++; $display("FAIL busy_second got %h/%h want 0077/%h", bcd0, hex1, exp_hex(77, 1'b0, 1'b1)); end
  endtask

  task automatic test_rst_mid();
    int lat;
    bit held;
    in_value = 16'd1234; in_blank = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vec++; if (hex0 !== 28'hFFFFFFF || bcd0 !== 16'h0000 || ov0 !== 1'b0) begin miscmp++; $display("FAIL rstmid_out got %h/%h/%b want fffffff/0000/0", hex0, bcd0, ov0); end
    vec++; if (ready0 !== 1'b1 || busy0 !== 1'b0) begin miscmp++; $display("FAIL rstmid_hs got rdy=%b busy=%b want 1/0", ready0, busy0); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    push(8, 1'b0, lat, held);
    vec++; if (lat != LAT) begin miscmp++; $display("FAIL rstmid_latency got %0d want %0d", lat, LAT); end
    vec++; if (bcd0 !== 16'h0008 || hex0 !== exp_hex(8, 1'b0, 1'b0)) begin miscmp++; $display("FAIL rstmid_next got %h/%h want 0008/%h", bcd0, hex0, exp_hex(8, 1'b0, 1'b0)); end
  endtask

  task automatic test_random();
    int lat, v;
    bit held, b;
    for (int n = 0; n < 25; n++) begin
      v = int'($urandom_range(0, 65535));
      b = 1'($urandom_range(0, 3) == 0);
      push(v, b, lat, held);
      vec++; if (lat != LAT || !held) begin miscmp++; $display("FAIL rnd_timing v=%0d got lat=%0d held=%b want %0d/1", v, lat, held, LAT); end
      vec++; if (bcd0 !== exp_bcd(v) || ov0 !== exp_ov(v)) begin miscmp++; $display("FAIL rnd_bcd v=%0d got %h/%b want %h/%b", v, bcd0, ov0, exp_bcd(v), exp_ov(v)); end
      vec++; if (hex0 !== exp_hex(v, b, 1'b0)) begin miscmp++; $display("FAIL rnd_hex v=%0d b=%b got %h want %h", v, b, hex0, exp_hex(v, b, 1'b0)); end
      vec++; if (hex1 !== exp_hex(v, b, 1'b1)) begin miscmp++; $display("FAIL rnd_hex_bl v=%0d b=%b got %h want %h", v, b, hex1, exp_hex(v, b, 1'b1)); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_value = '0; in_blank = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_directed();
    test_blank();
    test_busy_ignore();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
